// File: rtl/beamformer_pkg.sv
// Shared definitions for the beamformer energy path: default sample width,
// the integrator state encoding and the accumulator sizing rule.
package beamformer_pkg;

    // Width of the signed beam sum produced by the summing stage.
    localparam int DATA_W_DEF = 36;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } beam_state_e;

    // Accumulator width that holds window samples of full-scale magnitude
    // (2^(data_w-1) each) without overflow.
    function automatic int acc_width(input int data_w, input int window);
        return data_w + $clog2(window);
    endfunction

endpackage

// File: rtl/beam_abs_mag.sv
// Combinational signed-to-unsigned magnitude. The result keeps the full
// DATA_W bits so the most negative input maps to 2^(DATA_W-1) exactly.
module beam_abs_mag
    import beamformer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0] value,
    output logic        [DATA_W-1:0] mag
);

    logic              sign;
    logic [DATA_W-1:0] inv;

    assign sign = value[DATA_W-1];

    // Conditional one's complement; the +sign below completes two's negation.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_inv
            assign inv[gi] = value[gi] ^ sign;
        end
    endgenerate

    assign mag = inv + DATA_W'(sign);

endmodule

// File: rtl/beam_energy_integrator.sv
// Beam energy integrator: sums |summed_value| over WINDOW accepted samples
// and presents the total on a valid/ready output. While a result is pending
// no input is accepted, so windows never overlap. clear aborts the current
// window and drops any pending result.
// Optional build macro: BEAM_ENERGY_PEAK_EN adds per-window peak magnitude
// tracking and the peak_mag output port.
module beam_energy_integrator
    import beamformer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int WINDOW = 64,
    parameter int ACC_W  = acc_width(DATA_W, WINDOW)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] summed_value,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     clear,
    output logic        [ACC_W-1:0]  energy,
    output logic                     out_valid,
`ifdef BEAM_ENERGY_PEAK_EN
    output logic        [DATA_W-1:0] peak_mag,
`endif
    input  logic                     out_ready
);

    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] WIN_M1 = CNT_W'(WINDOW - 1);

    beam_state_e       state_reg, state_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [ACC_W-1:0]  energy_reg, energy_next;
    logic              out_valid_reg, out_valid_next;

    logic [DATA_W-1:0] mag;
    logic [ACC_W-1:0]  mag_ext;
    logic [ACC_W-1:0]  acc_sum;
    logic              handshake;

`ifdef BEAM_ENERGY_PEAK_EN
    logic [DATA_W-1:0] peak_run_reg, peak_run_next;
    logic [DATA_W-1:0] peak_out_reg, peak_out_next;
    logic [DATA_W-1:0] peak_max;
`endif

    beam_abs_mag #(
        .DATA_W (DATA_W)
    ) u_abs (
        .value (summed_value),
        .mag   (mag)
    );

    assign mag_ext   = ACC_W'(mag);
    assign acc_sum   = acc_reg + mag_ext;
    assign in_ready  = rst_n && (state_reg != HOLD) && !clear;
    assign handshake = in_valid && in_ready;
    assign energy    = energy_reg;
    assign out_valid = out_valid_reg;

`ifdef BEAM_ENERGY_PEAK_EN
    assign peak_max = (mag > peak_run_reg) ? mag : peak_run_reg;
    assign peak_mag = peak_out_reg;
`endif

    // Next-state and datapath updates; clear overrides any handshake or transfer.
    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        count_next     = count_reg;
        energy_next    = energy_reg;
        out_valid_next = out_valid_reg;
`ifdef BEAM_ENERGY_PEAK_EN
        peak_run_next  = peak_run_reg;
        peak_out_next  = peak_out_reg;
`endif
        if (clear) begin
            state_next     = IDLE;
            acc_next       = '0;
            count_next     = '0;
            out_valid_next = 1'b0;
`ifdef BEAM_ENERGY_PEAK_EN
            peak_run_next  = '0;
            peak_out_next  = '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        acc_next   = mag_ext;
                        count_next = CNT_W'(1);
`ifdef BEAM_ENERGY_PEAK_EN
                        peak_run_next = mag;
`endif
                        if (WINDOW == 1) begin
                            energy_next    = mag_ext;
                            out_valid_next = 1'b1;
`ifdef BEAM_ENERGY_PEAK_EN
                            peak_out_next  = mag;
`endif
                            state_next     = HOLD;
                        end else begin
                            state_next = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (handshake) begin
                        acc_next   = acc_sum;
                        count_next = count_reg + CNT_W'(1);
`ifdef BEAM_ENERGY_PEAK_EN
                        peak_run_next = peak_max;
`endif
                        if (count_reg == WIN_M1) begin
                            energy_next    = acc_sum;
                            out_valid_next = 1'b1;
`ifdef BEAM_ENERGY_PEAK_EN
                            peak_out_next  = peak_max;
`endif
                            state_next     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_next = 1'b0;
                        acc_next       = '0;
                        count_next     = '0;
`ifdef BEAM_ENERGY_PEAK_EN
                        peak_run_next  = '0;
                        peak_out_next  = '0;
`endif
                        state_next     = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            count_reg     <= '0;
            energy_reg    <= '0;
            out_valid_reg <= 1'b0;
`ifdef BEAM_ENERGY_PEAK_EN
            peak_run_reg  <= '0;
            peak_out_reg  <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            count_reg     <= count_next;
            energy_reg    <= energy_next;
            out_valid_reg <= out_valid_next;
`ifdef BEAM_ENERGY_PEAK_EN
            peak_run_reg  <= peak_run_next;
            peak_out_reg  <= peak_out_next;
`endif
        end
    end

endmodule

// File: tb/tb_beam_energy_integrator.sv
// Testbench for beam_energy_integrator: a WINDOW=4 instance driven by
// directed and random stimulus against a queue-based reference model, and
// a WINDOW=64 instance for the full-scale overflow case.
module tb_beam_energy_integrator;

    localparam int  DW   = 36;
    localparam int  AW4  = 38;
    localparam int  AW64 = 42;
    localparam longint MIN_VAL = -(64'sd1 <<< 35);
    localparam longint MAX_VAL = (64'sd1 <<< 35) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n;

    logic signed [DW-1:0] summed_value;
    logic                 in_valid, in_ready, clear, out_valid, out_ready;
    logic [AW4-1:0]       energy;

    logic signed [DW-1:0] value64;
    logic                 in_valid64, in_ready64, clear64, out_valid64, out_ready64;
    logic [AW64-1:0]      energy64;

`ifdef BEAM_ENERGY_PEAK_EN
    logic [DW-1:0]        peak_mag, peak_mag64;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint q[$];
    bit     m_pending;
    longint m_energy;
    longint m_peak;
    bit     obs_in_ready;
    bit     exp_in_ready;

    always #5 clk = ~clk;

    beam_energy_integrator #(.DATA_W(DW), .WINDOW(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .summed_value (summed_value),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .clear        (clear),
        .energy       (energy),
        .out_valid    (out_valid),
`ifdef BEAM_ENERGY_PEAK_EN
        .peak_mag     (peak_mag),
`endif
        .out_ready    (out_ready)
    );

    beam_energy_integrator #(.DATA_W(DW), .WINDOW(64)) dut64 (
        .clk          (clk),
        .rst_n        (rst_n),
        .summed_value (value64),
        .in_valid     (in_valid64),
        .in_ready     (in_ready64),
        .clear        (clear64),
        .energy       (energy64),
        .out_valid    (out_valid64),
`ifdef BEAM_ENERGY_PEAK_EN
        .peak_mag     (peak_mag64),
`endif
        .out_ready    (out_ready64)
    );

    function automatic longint absval(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    // One clock cycle on the WINDOW=4 instance: drive inputs, sample in_ready,
    // advance the model by the window rules, then move past the edge.
    task automatic apply(input bit v, input longint x, input bit c, input bit r);
        longint mx;
        in_valid     = v;
        summed_value = x[DW-1:0];
        clear        = c;
        out_ready    = r;
        #1;
        obs_in_ready = in_ready;
        exp_in_ready = rst_n && !m_pending && !c;
        if (!rst_n) begin
            q.delete(); m_pending = 0; m_energy = 0; m_peak = 0;
        end else if (c) begin
            q.delete(); m_pending = 0; m_peak = 0;
        end else if (m_pending) begin
            if (r) begin
                q.delete(); m_pending = 0; m_peak = 0;
            end
        end else if (v) begin
            q.push_back(absval(x));
            if (q.size() == 4) begin
                m_energy = q.sum();
                mx = 0;
                foreach (q[k]) if (q[k] > mx) mx = q[k];
                m_peak = mx;
                m_pending = 1;
                q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid64 = 0; value64 = '0; clear64 = 0; out_ready64 = 0;
        apply(0, 0, 0, 0);
        apply(1, 7, 0, 0);
        checks++;
        if (obs_in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %0b expected 0", obs_in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || longint'(energy) !== 0) begin
            errors++; $display("FAIL reset_outputs: out_valid=%0b energy=%0d expected 0/0", out_valid, energy);
        end
        checks++;
        if (out_valid64 !== 1'b0 || longint'(energy64) !== 0) begin
            errors++; $display("FAIL reset_outputs64: out_valid=%0b energy=%0d expected 0/0", out_valid64, energy64);
        end
        rst_n = 1'b1;
        apply(0, 0, 0, 0);
        checks++;
        if (obs_in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready: got %0b expected 1", obs_in_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        longint vals[4] = '{10, -20, 30, -40};
        for (int i = 0; i < 4; i++) begin
            apply(1, vals[i], 0, 0);
            if (i == 2) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL basic_early_valid: got %0b expected 0", out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || longint'(energy) !== 100 || m_energy !== 100) begin
            errors++; $display("FAIL basic_energy: out_valid=%0b energy=%0d expected 1/100", out_valid, energy);
        end
        apply(0, 0, 0, 0);
        checks++;
        if (obs_in_ready !== 1'b0) begin
            errors++; $display("FAIL basic_hold_in_ready: got %0b expected 0", obs_in_ready);
        end
        apply(0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_transfer: out_valid=%0b expected 0", out_valid);
        end
        $display("test_basic done");
    endtask

    task automatic test_backpressure();
        longint held;
        for (int i = 0; i < 4; i++) apply(1, longint'($urandom_range(0, 2000)) - 1000, 0, 0);
        held = m_energy;
        for (int i = 0; i < 5; i++) begin
            apply(1, longint'($urandom_range(1, 500)), 0, 0);
            checks++;
            if (obs_in_ready !== 1'b0 || out_valid !== 1'b1 || longint'(energy) !== held) begin
                errors++;
                $display("FAIL bp_hold[%0d]: in_ready=%0b out_valid=%0b energy=%0d expected 0/1/%0d",
                         i, obs_in_ready, out_valid, energy, held);
            end
        end
        apply(1, 999, 0, 1);
        checks++;
        if (obs_in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_transfer: in_ready=%0b out_valid=%0b expected 0/0", obs_in_ready, out_valid);
        end
        for (int i = 1; i <= 4; i++) apply(1, i, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || longint'(energy) !== 10) begin
            errors++; $display("FAIL bp_fresh_window: out_valid=%0b energy=%0d expected 1/10", out_valid, energy);
        end
        apply(0, 0, 0, 1);
        $display("test_backpressure done");
    endtask

    task automatic test_clear();
        apply(1, 100, 0, 0);
        apply(1, -200, 0, 0);
        apply(1, 1000, 1, 0);
        checks++;
        if (obs_in_ready !== 1'b0) begin
            errors++; $display("FAIL clear_in_ready: got %0b expected 0", obs_in_ready);
        end
        for (int i = 0; i < 4; i++) apply(1, 1, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || longint'(energy) !== 4) begin
            errors++; $display("FAIL clear_energy: out_valid=%0b energy=%0d expected 1/4", out_valid, energy);
        end
        apply(0, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL clear_pending: out_valid=%0b expected 0", out_valid);
        end
        $display("test_clear done");
    endtask

    task automatic test_reset_hold();
        for (int i = 0; i < 4; i++) apply(1, MIN_VAL, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || longint'(energy) !== (64'sd1 <<< 37)) begin
            errors++; $display("FAIL min_val_energy: out_valid=%0b energy=%0d expected 1/%0d",
                               out_valid, energy, 64'sd1 <<< 37);
        end
        rst_n = 1'b0;
        apply(0, 0, 0, 0);
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || longint'(energy) !== 0) begin
            errors++; $display("FAIL reset_in_hold: out_valid=%0b energy=%0d expected 0/0", out_valid, energy);
        end
        apply(0, 0, 0, 0);
        $display("test_reset_hold done");
    endtask

    task automatic test_window64();
        for (int i = 0; i < 64; i++) begin
            in_valid64 = 1'b1;
            value64    = MIN_VAL[DW-1:0];
            @(posedge clk);
            #1;
            if (i == 62) begin
                checks++;
                if (out_valid64 !== 1'b0) begin
                    errors++; $display("FAIL w64_early_valid: got %0b expected 0", out_valid64);
                end
            end
        end
        in_valid64 = 1'b0;
        #1;
        checks++;
        if (out_valid64 !== 1'b1 || longint'(energy64) !== (64'sd1 <<< 41) || in_ready64 !== 1'b0) begin
            errors++; $display("FAIL w64_energy: out_valid=%0b energy=%0d in_ready=%0b expected 1/%0d/0",
                               out_valid64, energy64, in_ready64, 64'sd1 <<< 41);
        end
        out_ready64 = 1'b1;
        @(posedge clk);
        #1;
        out_ready64 = 1'b0;
        checks++;
        if (out_valid64 !== 1'b0) begin
            errors++; $display("FAIL w64_transfer: out_valid=%0b expected 0", out_valid64);
        end
        $display("test_window64 done");
    endtask

`ifdef BEAM_ENERGY_PEAK_EN
    task automatic test_peak();
        longint vals[4] = '{5, -9, 3, 7};
        for (int i = 0; i < 4; i++) apply(1, vals[i], 0, 0);
        checks++;
        if (longint'(peak_mag) !== 9 || longint'(energy) !== 24) begin
            errors++; $display("FAIL peak: peak_mag=%0d energy=%0d expected 9/24", peak_mag, energy);
        end
        apply(0, 0, 0, 1);
        $display("test_peak done");
    endtask
`endif

    task automatic test_random();
        bit     v, c, r;
        longint x;
        int     sel;
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 99) < 75);
            c   = ($urandom_range(0, 99) < 4);
            r   = ($urandom_range(0, 99) < 50);
            sel = $urandom_range(0, 19);
            if (sel == 0)      x = MIN_VAL;
            else if (sel == 1) x = MAX_VAL;
            else               x = longint'($urandom_range(0, 2000000)) - 1000000;
            rst_n = ($urandom_range(0, 99) >= 2);
            apply(v, x, c, r);
            checks++;
            if (obs_in_ready !== exp_in_ready) begin
                errors++; $display("FAIL rand_in_ready[%0d]: got %0b expected %0b", n, obs_in_ready, exp_in_ready);
            end
            checks++;
            if (out_valid !== m_pending || longint'(energy) !== m_energy) begin
                errors++; $display("FAIL rand_out[%0d]: out_valid=%0b energy=%0d expected %0b/%0d",
                                   n, out_valid, energy, m_pending, m_energy);
            end
`ifdef BEAM_ENERGY_PEAK_EN
            checks++;
            if (longint'(peak_mag) !== m_peak) begin
                errors++; $display("FAIL rand_peak[%0d]: got %0d expected %0d", n, peak_mag, m_peak);
            end
`endif
        end
        rst_n = 1'b1;
        $display("test_random done");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        m_pending = 0; m_energy = 0; m_peak = 0;
        in_valid = 0; summed_value = '0; clear = 0; out_ready = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_clear();
        test_reset_hold();
        test_window64();
`ifdef BEAM_ENERGY_PEAK_EN
        test_peak();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
